pc_gen: RTL and testbench

//  Parametrised program-counter generator for the fetch stage; next generation of the basic PC register.

---
 rtl/pc_gen_if.sv | 25 ++
 rtl/pc_gen.sv | 90 +++++++++
 tb/tb_pc_gen.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/pc_gen_if.sv
// Fetch-side bundle between the control unit, the PC generator and the instruction ROM.
// The PC generator takes the slave view; whoever drives stall/flush/branches takes the master view.
interface pc_gen_if #(
    parameter int ADDR_W = 32
);
    logic              stall;
    logic              flush;
    logic [ADDR_W-1:0] new_pc;
    logic              branch_flag;
    logic [ADDR_W-1:0] branch_target;
    logic [ADDR_W-1:0] pc;
    logic              ce;
    logic              pend_valid;
    logic              addr_misalign;

    modport master (
        output stall, flush, new_pc, branch_flag, branch_target,
        input  pc, ce, pend_valid, addr_misalign
    );

    modport slave (
        input  stall, flush, new_pc, branch_flag, branch_target,
        output pc, ce, pend_valid, addr_misalign
    );
endinterface

// File: rtl/pc_gen.sv
// Program-counter generator for the fetch stage: reset vector, sequential step, stall hold,
// branch redirect, flush redirect, and a one-entry buffer for branches that arrive during a stall.
module pc_gen #(
    parameter int              ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0,
    parameter int              STEP      = 4,
    parameter int              ALIGN_LSB = 2
) (
    input  logic      clk,
    input  logic      rst,
    pc_gen_if.slave   pcBus
);

    // StRst holds ce low; the first edge out of it is the boot edge, which only raises ce
    // so that the first fetch is at RESET_VEC and all redirects are ignored.
    typedef enum logic {
        StRst,
        StRun
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              pendValid_q, pendValid_d;
    logic [ADDR_W-1:0] pendTarget_q, pendTarget_d;
    logic              ceOut;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StRst;
            pc_q         <= RESET_VEC;
            pendValid_q  <= 1'b0;
            pendTarget_q <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pendValid_q  <= pendValid_d;
            pendTarget_q <= pendTarget_d;
        end
    end

    // In RUN the rules are strictly ordered: flush, stall, fresh branch, buffered branch, step.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pendValid_d  = pendValid_q;
        pendTarget_d = pendTarget_q;
        unique case (state_q)
            StRst: begin
                state_d = StRun;
            end
            StRun: begin
                if (pcBus.flush) begin
                    pc_d        = pcBus.new_pc;
                    pendValid_d = 1'b0;
                end else if (pcBus.stall) begin
                    if (pcBus.branch_flag) begin
                        pendTarget_d = pcBus.branch_target;
                        pendValid_d  = 1'b1;
                    end
                end else if (pcBus.branch_flag) begin
                    pc_d        = pcBus.branch_target;
                    pendValid_d = 1'b0;
                end else if (pendValid_q) begin
                    pc_d        = pendTarget_q;
                    pendValid_d = 1'b0;
                end else begin
                    pc_d = pc_q + ADDR_W'(STEP);
                end
            end
            default: begin
                state_d = StRst;
            end
        endcase
    end

    assign ceOut            = (state_q == StRun);
    assign pcBus.ce         = ceOut;
    assign pcBus.pc         = pc_q;
    assign pcBus.pend_valid = pendValid_q;

    // Misalignment is only flagged, never corrected; a zero-width check is disabled.
    generate
        if (ALIGN_LSB == 0) begin : gNoAlign
            assign pcBus.addr_misalign = 1'b0;
        end else begin : gAlign
            assign pcBus.addr_misalign = ceOut && (pc_q[ALIGN_LSB-1:0] != '0);
        end
    endgenerate

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: a 32-bit and an 8-bit instance share directed and random stimulus
// and are compared every cycle against a rule-level reference model.
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        flush;
    logic [31:0] newPc;
    logic        branchFlag;
    logic [31:0] branchTarget;

    int checks = 0;
    int errors = 0;

    // Model state, index 0 = 32-bit instance, index 1 = 8-bit instance
    logic [31:0] mPc[2];
    bit          mCe[2];
    bit          mHavePend[2];
    logic [31:0] mPendTarget[2];

    pc_gen_if #(.ADDR_W(32)) bus32 ();
    pc_gen_if #(.ADDR_W(8))  bus8 ();

    assign bus32.stall         = stall;
    assign bus32.flush         = flush;
    assign bus32.new_pc        = newPc;
    assign bus32.branch_flag   = branchFlag;
    assign bus32.branch_target = branchTarget;
    assign bus8.stall          = stall;
    assign bus8.flush          = flush;
    assign bus8.new_pc         = newPc[7:0];
    assign bus8.branch_flag    = branchFlag;
    assign bus8.branch_target  = branchTarget[7:0];

    pc_gen #(.ADDR_W(32), .RESET_VEC(32'h0), .STEP(4), .ALIGN_LSB(2)) dut32 (
        .clk   (clk),
        .rst   (rst),
        .pcBus (bus32)
    );

    pc_gen #(.ADDR_W(8), .RESET_VEC(8'h0), .STEP(4), .ALIGN_LSB(2)) dut8 (
        .clk   (clk),
        .rst   (rst),
        .pcBus (bus8)
    );

    always #5 clk = ~clk;

    task automatic compare(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic modelStep();
        for (int k = 0; k < 2; k++) begin
            logic [31:0] msk;
            msk = (k == 0) ? 32'hFFFF_FFFF : 32'h0000_00FF;
            if (rst) begin
                mCe[k]         = 1'b0;
                mPc[k]         = 32'h0;
                mHavePend[k]   = 1'b0;
                mPendTarget[k] = 32'h0;
            end else if (!mCe[k]) begin
                mCe[k] = 1'b1;
            end else if (flush) begin
                mPc[k]       = newPc & msk;
                mHavePend[k] = 1'b0;
            end else if (stall) begin
                if (branchFlag) begin
                    mPendTarget[k] = branchTarget & msk;
                    mHavePend[k]   = 1'b1;
                end
            end else if (branchFlag) begin
                mPc[k]       = branchTarget & msk;
                mHavePend[k] = 1'b0;
            end else if (mHavePend[k]) begin
                mPc[k]       = mPendTarget[k];
                mHavePend[k] = 1'b0;
            end else begin
                mPc[k] = (mPc[k] + 32'd4) % (64'(msk) + 64'd1);
            end
        end
    endtask

    task automatic checkOutput();
        compare("pc32",   bus32.pc,                   mPc[0]);
        compare("ce32",   {31'b0, bus32.ce},          {31'b0, mCe[0]});
        compare("pend32", {31'b0, bus32.pend_valid},  {31'b0, mHavePend[0]});
        compare("mis32",  {31'b0, bus32.addr_misalign},
                {31'b0, mCe[0] && (mPc[0] % 4 != 0)});
        compare("pc8",    {24'b0, bus8.pc},           mPc[1]);
        compare("ce8",    {31'b0, bus8.ce},           {31'b0, mCe[1]});
        compare("pend8",  {31'b0, bus8.pend_valid},   {31'b0, mHavePend[1]});
        compare("mis8",   {31'b0, bus8.addr_misalign},
                {31'b0, mCe[1] && (mPc[1] % 4 != 0)});
    endtask

    task automatic applyStimulus(input logic r, input logic st, input logic fl, input logic [31:0] np,
                                 input logic bf, input logic [31:0] bt);
        rst          = r;
        stall        = st;
        flush        = fl;
        newPc        = np;
        branchFlag   = bf;
        branchTarget = bt;
        @(posedge clk);
        modelStep();
        #1;
        checkOutput();
    endtask

    initial begin
        mPc         = '{32'h0, 32'h0};
        mCe         = '{1'b0, 1'b0};
        mHavePend   = '{1'b0, 1'b0};
        mPendTarget = '{32'h0, 32'h0};

        // Reset for two cycles, then boot and count up to 0x10
        applyStimulus(1, 0, 0, 32'h0, 0, 32'h0);
        applyStimulus(1, 0, 0, 32'h0, 0, 32'h0);
        compare("t1_rst_ce", {31'b0, bus32.ce}, 32'h0);
        applyStimulus(0, 0, 0, 32'h0, 0, 32'h0);
        compare("t1_boot_ce", {31'b0, bus32.ce}, 32'h1);
        compare("t1_boot_pc", bus32.pc, 32'h0);
        applyStimulus(0, 0, 0, 32'h0, 0, 32'h0);
        compare("t1_pc4", bus32.pc, 32'h4);
        applyStimulus(0, 0, 0, 32'h0, 0, 32'h0);
        applyStimulus(0, 0, 0, 32'h0, 0, 32'h0);
        compare("t1_pcC", bus32.pc, 32'hC);
        applyStimulus(0, 0, 0, 32'h0, 0, 32'h0);

        // Plain stall for three edges
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1, 0, 32'h0, 0, 32'h0);
            compare("t2_hold", bus32.pc, 32'h10);
        end
        applyStimulus(0, 0, 0, 32'h0, 0, 32'h0);
        compare("t2_release", bus32.pc, 32'h14);

        // Branch buffered during stall, applied on release
        applyStimulus(0, 1, 0, 32'h0, 1, 32'h100);
        compare("t3_pend", {31'b0, bus32.pend_valid}, 32'h1);
        applyStimulus(0, 1, 0, 32'h0, 0, 32'h0);
        compare("t3_hold", bus32.pc, 32'h14);
        applyStimulus(0, 0, 0, 32'h0, 0, 32'h0);
        compare("t3_target", bus32.pc, 32'h100);
        applyStimulus(0, 0, 0, 32'h0, 0, 32'h0);
        compare("t3_next", bus32.pc, 32'h104);

        // Flush beats stall, branch and a buffered branch
        applyStimulus(0, 1, 0, 32'h0, 1, 32'h300);
        applyStimulus(0, 1, 1, 32'h20, 1, 32'h200);
        compare("t4_pc", bus32.pc, 32'h20);
        compare("t4_pend", {31'b0, bus32.pend_valid}, 32'h0);
        applyStimulus(0, 0, 0, 32'h0, 0, 32'h0);
        compare("t4_next", bus32.pc, 32'h24);

        // Wrap on the 8-bit instance and misalignment flag
        applyStimulus(0, 0, 0, 32'h0, 1, 32'hFC);
        applyStimulus(0, 0, 0, 32'h0, 0, 32'h0);
        compare("t5_wrap8", {24'b0, bus8.pc}, 32'h0);
        compare("t5_nowrap32", bus32.pc, 32'h100);
        applyStimulus(0, 0, 0, 32'h0, 1, 32'h42);
        compare("t5_mis8", {31'b0, bus8.addr_misalign}, 32'h1);
        applyStimulus(0, 0, 0, 32'h0, 1, 32'h40);
        compare("t5_aligned", {31'b0, bus32.addr_misalign}, 32'h0);

        // Reset while a branch is buffered and stall is high
        applyStimulus(0, 1, 0, 32'h0, 1, 32'h500);
        compare("t6_pend", {31'b0, bus32.pend_valid}, 32'h1);
        applyStimulus(1, 1, 0, 32'h0, 0, 32'h0);
        compare("t6_ce", {31'b0, bus32.ce}, 32'h0);
        compare("t6_pc", bus32.pc, 32'h0);
        compare("t6_pend_lost", {31'b0, bus32.pend_valid}, 32'h0);
        applyStimulus(0, 1, 1, 32'h80, 1, 32'h90);
        compare("t6_boot_ignores", bus32.pc, 32'h0);
        applyStimulus(0, 0, 0, 32'h0, 0, 32'h0);
        compare("t6_reboot", bus32.pc, 32'h4);

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            logic        r, st, fl, bf;
            logic [31:0] np, bt;
            r  = ($urandom_range(0, 49) == 0);
            st = ($urandom_range(0, 2) == 0);
            fl = ($urandom_range(0, 9) == 0);
            bf = ($urandom_range(0, 3) == 0);
            np = $urandom;
            bt = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                np = np & 32'hFFFF_FFFC;
                bt = bt & 32'hFFFF_FFFC;
            end
            applyStimulus(r, st, fl, np, bf, bt);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
